// File: rtl/sc_dmem_arbiter.sv
// Two-master round-robin arbiter for the single-cycle computer's data memory port.
// Each transaction takes IDLE -> ISSUE -> RESP. A DMA burst lock can hold the port for up to MAX_LOCK grants.
module sc_dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic          dma_lock,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner,
    output logic          busy
);

    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          last_owner;
    logic [CW-1:0] lock_cnt;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          any_req;
    logic          lock_active;
    logic          grant_dma;

    assign any_req     = cpu_req | dma_req;
    assign lock_active = dma_lock & last_owner & (lock_cnt != '0) & (lock_cnt < LOCK_MAX);
    // On a tie the locked DMA keeps the port, otherwise whoever was not served last wins.
    assign grant_dma   = (cpu_req & dma_req) ? (lock_active | ~last_owner) : dma_req;

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (any_req) state_next = ISSUE;
            ISSUE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments; reset is sampled on the clock edge only.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            lock_cnt   <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && any_req) begin
                owner      <= grant_dma;
                last_owner <= grant_dma;
                we_q       <= grant_dma ? dma_we    : cpu_we;
                addr_q     <= grant_dma ? dma_addr  : cpu_addr;
                wdata_q    <= grant_dma ? dma_wdata : cpu_wdata;
                if (grant_dma && dma_lock)
                    lock_cnt <= (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + CW'(1);
                else
                    lock_cnt <= '0;
            end
        end
    end

    // Request fields are frozen in the latches above, so a master may change its inputs mid-transaction.
    assign mem_en    = (state == ISSUE);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign cpu_ack   = (state == RESP) & ~owner;
    assign dma_ack   = (state == RESP) &  owner;
    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;
    assign cpu_stall = cpu_req & ~cpu_ack;
    assign busy      = (state != IDLE);

endmodule
